// File: rtl/pixel_write_sink_pkg.sv
// Shared definitions for the pixel write sink: FSM state encoding, screen
// geometry defaults and named colours.
package pixel_write_sink_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam int WIDTH_DEF      = 160;
  localparam int HEIGHT_DEF     = 120;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int ADDR_W_DEF     = 15;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;

endpackage

// File: rtl/pixel_write_sink_fifo.sv
// Synchronous pixel queue. Storage is not reset; only pointers and count are.
// The caller guarantees no push while full and no pop while empty.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  assign full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_write_sink.sv
// Receives plot requests, queues them, and drains them into a single-port
// framebuffer write port with a ready stall; also sweeps a full-screen clear.
module pixel_write_sink
  import pixel_write_sink_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int HEIGHT     = HEIGHT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              plot,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic [2:0]        colour,
  input  logic              clear,
  input  logic [2:0]        clear_colour,
  output logic              full,
  output logic              busy,
  output logic              clear_done,
  output logic [7:0]        drop_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ready
);

  localparam int PIX_W = ADDR_W + 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
    return ADDR_W'(py) * ADDR_W'(WIDTH) + ADDR_W'(px);
  endfunction

  state_e            state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        mem_data_q, mem_data_d;
  logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic              sweep_last_q, sweep_last_d;
  logic              clr_pend_q, clr_pend_d;
  logic [2:0]        clr_colour_q, clr_colour_d;
  logic              clear_done_q, clear_done_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic             in_range, push, pop, drop, accept, can_load;
  logic             fifo_full, fifo_empty;
  logic [PIX_W-1:0] fifo_dout;

  assign in_range = ({24'd0, x} < 32'(WIDTH)) && ({25'd0, y} < 32'(HEIGHT));
  assign push     = plot && !fifo_full && in_range;
  assign drop     = plot && (fifo_full || !in_range);
  assign accept   = mem_we_q && mem_ready;
  assign can_load = !mem_we_q || mem_ready;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk   (clock),
    .rst_n (resetn),
    .push  (push),
    .din   ({pix_addr(x, y), colour}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    sweep_cnt_d  = sweep_cnt_q;
    sweep_last_d = sweep_last_q;
    clr_pend_d   = clr_pend_q;
    clr_colour_d = clr_colour_q;
    clear_done_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    pop          = 1'b0;

    if (accept) mem_we_d = 1'b0;
    if (clear) clr_colour_d = clear_colour;
    // A clear during a sweep restarts it directly rather than queueing another.
    if (clear && state_q != CLEAR) clr_pend_d = 1'b1;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = fifo_dout[PIX_W-1:3];
          mem_data_d = fifo_dout[2:0];
          state_d    = DRAIN;
        end else if (clr_pend_q) begin
          state_d      = CLEAR;
          sweep_cnt_d  = '0;
          sweep_last_d = 1'b0;
          clr_pend_d   = 1'b0;
        end
      end
      DRAIN: begin
        if (!fifo_empty) begin
          if (can_load) begin
            pop        = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = fifo_dout[PIX_W-1:3];
            mem_data_d = fifo_dout[2:0];
          end
        end else if (can_load) begin
          if (clr_pend_q) begin
            state_d      = CLEAR;
            sweep_cnt_d  = '0;
            sweep_last_d = 1'b0;
            clr_pend_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CLEAR: begin
        if (clear) begin
          sweep_cnt_d  = '0;
          sweep_last_d = 1'b0;
        end else if (sweep_last_q) begin
          if (accept) begin
            clear_done_d = 1'b1;
            state_d      = fifo_empty ? IDLE : DRAIN;
          end
        end else if (can_load) begin
          mem_we_d   = 1'b1;
          mem_addr_d = sweep_cnt_q;
          mem_data_d = clr_colour_q;
          if (sweep_cnt_q == LAST_ADDR) sweep_last_d = 1'b1;
          else                          sweep_cnt_d  = sweep_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      sweep_cnt_q  <= '0;
      sweep_last_q <= 1'b0;
      clr_pend_q   <= 1'b0;
      clr_colour_q <= '0;
      clear_done_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      sweep_cnt_q  <= sweep_cnt_d;
      sweep_last_q <= sweep_last_d;
      clr_pend_q   <= clr_pend_d;
      clr_colour_q <= clr_colour_d;
      clear_done_q <= clear_done_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign full       = fifo_full;
  assign busy       = !fifo_empty || clr_pend_q || (state_q == CLEAR) || mem_we_q;
  assign clear_done = clear_done_q;
  assign drop_count = drop_cnt_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Scoreboard bench for pixel_write_sink: expected framebuffer writes are queued
// by the stimulus and checked in order by a monitor on each accepted transfer.
module tb_pixel_write_sink;

  logic        clock = 1'b0;
  logic        resetn, plot, clear, mem_ready;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour, clear_colour;
  logic        full, busy, clear_done, mem_we;
  logic [7:0]  drop_count;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_assert = 0;
  int  n_fail   = 0;
  int  done_cnt = 0;

  pixel_write_sink dut (
    .clock        (clock),
    .resetn       (resetn),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .clear        (clear),
    .clear_colour (clear_colour),
    .full         (full),
    .busy         (busy),
    .clear_done   (clear_done),
    .drop_count   (drop_count),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready)
  );

  always #5 clock = ~clock;

  function automatic wr_t mk(input int a, input int d);
    wr_t w;
    w.addr = 15'(a);
    w.data = 3'(d);
    return w;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the next posedge whenever mem_we && mem_ready.
  always @(negedge clock) begin
    if (resetn && mem_we && mem_ready) begin
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", mem_addr, mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.addr || mem_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL write_order: got addr %0d data %0d, expected addr %0d data %0d",
                   mem_addr, mem_data, mon_e.addr, mon_e.data);
        end
      end
    end
    if (resetn && clear_done) done_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_plot(input int px, input int py, input int c);
    plot = 1'b1; x = 8'(px); y = 7'(py); colour = 3'(c);
    tick();
    plot = 1'b0;
  endtask

  task automatic do_clear(input int c);
    clear = 1'b1; clear_colour = 3'(c);
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, (busy || exp_q.size() != 0) ? 1 : 0, 0);
    tick();
  endtask

  initial begin
    int d0;
    int c0;
    resetn = 1'b0; plot = 1'b0; clear = 1'b0; x = '0; y = '0; colour = '0;
    clear_colour = '0; mem_ready = 1'b0;
    repeat (3) tick();
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_mem_addr", mem_addr, 0);
    resetn = 1'b1;
    tick();

    // Single plot, latency and return to idle
    mem_ready = 1'b1;
    exp_q.push_back(mk(325, 4));
    do_plot(5, 2, 4);
    check("t1_we_after_N", mem_we, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_we_after_N1", mem_we, 1);
    check("t1_addr", mem_addr, 325);
    wait_drain(20, "t1_drain");
    check("t1_busy_idle", busy, 0);

    // Burst of 10 with memory stalled: 1 held + 8 queued, 1 dropped
    mem_ready = 1'b0;
    d0 = drop_count;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(mk(1620 + i, i % 8));
      do_plot(20 + i, 10, i % 8);
    end
    check("t2_full", full, 1);
    check("t2_drop", drop_count, d0 + 1);
    check("t2_we_held", mem_we, 1);
    repeat (3) tick();
    check("t2_addr_stable", mem_addr, 1620);
    check("t2_data_stable", mem_data, 0);
    mem_ready = 1'b1;
    wait_drain(40, "t2_drain");
    check("t2_full_after", full, 0);

    // Out-of-range plots are dropped with no write
    d0 = drop_count;
    do_plot(160, 0, 1);
    check("t3_drop_x", drop_count, d0 + 1);
    do_plot(0, 120, 1);
    check("t3_drop_y", drop_count, d0 + 2);
    tick();
    check("t3_busy", busy, 0);
    check("t3_we", mem_we, 0);

    // Full-screen clear to black
    for (int i = 0; i < 19200; i++) exp_q.push_back(mk(i, 0));
    c0 = done_cnt;
    do_clear(0);
    check("t4_busy", busy, 1);
    wait_drain(19400, "t4_drain");
    tick();
    check("t4_clear_done_once", done_cnt - c0, 1);

    // Clear while draining: queued pixels land first, mid-sweep plot lands last
    mem_ready = 1'b0;
    exp_q.push_back(mk(161, 1));
    exp_q.push_back(mk(162, 2));
    exp_q.push_back(mk(163, 3));
    do_plot(1, 1, 1);
    do_plot(2, 1, 2);
    do_plot(3, 1, 3);
    for (int i = 0; i < 19200; i++) exp_q.push_back(mk(i, 4));
    c0 = done_cnt;
    do_clear(4);
    mem_ready = 1'b1;
    repeat (100) tick();
    check("t5_sweeping", busy, 1);
    exp_q.push_back(mk(487, 2));
    do_plot(7, 3, 2);
    wait_drain(19500, "t5_drain");
    tick();
    check("t5_clear_done_once", done_cnt - c0, 1);

    // Reset in the middle of a sweep with a toggling ready
    for (int i = 0; i < 19200; i++) exp_q.push_back(mk(i, 2));
    c0 = done_cnt;
    do_clear(2);
    for (int i = 0; i < 200; i++) begin
      tick();
      mem_ready = ~mem_ready;
    end
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("t6_we_reset", mem_we, 0);
    check("t6_busy_reset", busy, 0);
    check("t6_drop_reset", drop_count, 0);
    check("t6_no_done", done_cnt - c0, 0);
    repeat (2) tick();
    resetn = 1'b1;
    mem_ready = 1'b1;
    tick();
    exp_q.push_back(mk(19199, 5));
    do_plot(159, 119, 5);
    check("t6_busy_after", busy, 1);
    wait_drain(20, "t6_drain");
    check("t6_drop_after", drop_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
